// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_stream
// UART transmitter fed by a valid/ready stream. Define UART_TX_STREAM_FIFO_EN
// to buffer words in a FIFO_DEPTH-entry FIFO instead of one holding register.
// Rev    : 1.0
// ============================================================================
module uart_tx_stream #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUDRATE      = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int MSB_FIRST     = 0,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic [DATA_BITS-1:0]        in_data,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int C_DIVISOR = (CLK_FREQUENCY + BAUDRATE / 2) / BAUDRATE;
    localparam int C_CW      = (C_DIVISOR < 2) ? 1 : $clog2(C_DIVISOR);
    localparam int C_LW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [C_CW-1:0] C_BAUD_LAST = C_CW'(C_DIVISOR - 1);
    localparam logic [3:0]      C_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      C_STOP_LAST = 4'(STOP_BITS - 1);

    if (C_DIVISOR < 2) begin : g_chk_divisor
        $error("uart_tx_stream: baud divisor must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_stream: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_tx_stream: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } t_state;

    t_state                 r_state;
    t_state                 w_state_nxt;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;
    logic [DATA_BITS-1:0]   w_rd_data;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic [C_CW-1:0]        r_baud_cnt;
    logic [3:0]             r_bit_cnt;
    logic                   r_tx;
    logic                   r_busy;
    logic                   w_tx_nxt;
    logic                   w_bit_done;
    logic                   w_shift_bit;

    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;

`ifdef UART_TX_STREAM_FIFO_EN
    localparam int C_AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_stream: FIFO_DEPTH must be a power of two, at least 2");
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [C_AW:0]        r_wr_ptr;
    logic [C_AW:0]        r_rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full    = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {C_AW{1'b0}}};
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_rd_data = r_mem[r_rd_ptr[C_AW-1:0]];
    assign level     = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (C_AW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (C_AW + 1)'(1);
            end
        end
    end
`else
    logic                 r_hold_valid;
    logic [DATA_BITS-1:0] r_hold_data;

    assign w_full    = r_hold_valid;
    assign w_empty   = !r_hold_valid;
    assign w_rd_data = r_hold_data;
    assign level     = C_LW'(r_hold_valid);

    // Push requires an empty register and pop a full one, so they never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_push) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= in_data;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    assign w_bit_done  = (r_baud_cnt == C_BAUD_LAST);
    assign w_shift_bit = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_done) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_nxt = w_shift_bit;
                if (w_bit_done && r_bit_cnt == C_DATA_LAST) begin
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_tx_nxt = r_parity;
                if (w_bit_done) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_done && r_bit_cnt == C_STOP_LAST) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_pop) begin
            r_shift    <= w_rd_data;
            r_parity   <= (PARITY == 1) ? ~^w_rd_data : ^w_rd_data;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (r_state != S_IDLE) begin
            if (w_bit_done) begin
                r_baud_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift <= (MSB_FIRST != 0) ? {r_shift[DATA_BITS-2:0], 1'b0}
                                                : {1'b0, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= (r_bit_cnt == C_DATA_LAST) ? 4'd0 : r_bit_cnt + 4'd1;
                end else if (r_state == S_STOP) begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + C_CW'(1);
            end
        end
    end

    // The pin lags the state register by one cycle so it comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_busy <= (r_state != S_IDLE);
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_stream
// Directed checks of framing, parity, bit order, buffering and reset.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx_stream;

`ifdef UART_TX_STREAM_FIFO_EN
    localparam int C_FULL_LVL  = 4;
    localparam int C_AFTER_POP = 3;
    localparam int C_RST_LVL   = 3;
`else
    localparam int C_FULL_LVL  = 1;
    localparam int C_AFTER_POP = 0;
    localparam int C_RST_LVL   = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    int         sel = 0;

    logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0, valid_d = 1'b0;
    logic [7:0] data_a = '0, data_b = '0, data_c = '0;
    logic [4:0] data_d = '0;
    logic       rdy_a, rdy_b, rdy_c, rdy_d;
    logic       tx_a, tx_b, tx_c, tx_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic [2:0] lvl_a;
    logic [4:0] lvl_b, lvl_c, lvl_d;
    logic       mon_tx, mon_busy;

    uart_tx_stream #(.CLK_FREQUENCY(1000000), .BAUDRATE(100000), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(valid_a), .in_data(data_a),
        .in_ready(rdy_a), .tx(tx_a), .busy(busy_a), .level(lvl_a));

    uart_tx_stream #(.CLK_FREQUENCY(1000000), .BAUDRATE(100000), .PARITY(2)) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(valid_b), .in_data(data_b),
        .in_ready(rdy_b), .tx(tx_b), .busy(busy_b), .level(lvl_b));

    uart_tx_stream #(.CLK_FREQUENCY(1000000), .BAUDRATE(100000), .PARITY(1)) u_c (
        .clk(clk), .reset_n(reset_n), .in_valid(valid_c), .in_data(data_c),
        .in_ready(rdy_c), .tx(tx_c), .busy(busy_c), .level(lvl_c));

    uart_tx_stream #(.CLK_FREQUENCY(1000000), .BAUDRATE(100000), .DATA_BITS(5),
                     .STOP_BITS(2), .MSB_FIRST(1)) u_d (
        .clk(clk), .reset_n(reset_n), .in_valid(valid_d), .in_data(data_d),
        .in_ready(rdy_d), .tx(tx_d), .busy(busy_d), .level(lvl_d));

    always_comb begin
        mon_tx   = tx_a;
        mon_busy = busy_a;
        case (sel)
            1: begin mon_tx = tx_b; mon_busy = busy_b; end
            2: begin mon_tx = tx_c; mon_busy = busy_c; end
            3: begin mon_tx = tx_d; mon_busy = busy_d; end
            default: ;
        endcase
    end

    // Pushes one word when idle and records the line; line[0] is edge N+2.
    task automatic send_one(input int s, input logic [7:0] d, output logic [299:0] line,
                            output int blen, output logic lat_tx, output logic lat_busy);
        sel = s;
        @(negedge clk);
        case (s)
            0: begin valid_a = 1'b1; data_a = d; end
            1: begin valid_b = 1'b1; data_b = d; end
            2: begin valid_c = 1'b1; data_c = d; end
            default: begin valid_d = 1'b1; data_d = d[4:0]; end
        endcase
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0; valid_d = 1'b0;
        @(negedge clk);
        lat_tx   = mon_tx;
        lat_busy = mon_busy;
        blen     = 0;
        line     = '1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            line[c] = mon_tx;
            if (mon_busy) blen++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tx_a, tx_b, tx_c, tx_d} !== 4'hF) begin
            n_err++; $display("FAIL reset_tx: got %b expected 1111", {tx_a, tx_b, tx_c, tx_d});
        end
        n_vec++;
        if ({busy_a, busy_b, busy_c, busy_d} !== 4'h0) begin
            n_err++; $display("FAIL reset_busy: got %b expected 0000", {busy_a, busy_b, busy_c, busy_d});
        end
        n_vec++;
        if (lvl_a !== 3'd0 || lvl_b !== 5'd0 || lvl_c !== 5'd0 || lvl_d !== 5'd0) begin
            n_err++; $display("FAIL reset_level: got %0d/%0d/%0d/%0d expected 0", lvl_a, lvl_b, lvl_c, lvl_d);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({rdy_a, rdy_b, rdy_c, rdy_d} !== 4'hF || tx_a !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got rdy %b tx %b expected 1111 1", {rdy_a, rdy_b, rdy_c, rdy_d}, tx_a);
        end
    endtask

    task automatic test_8n1;
        logic [299:0] line; int blen; logic lt, lb, e;
        logic [9:0] exp_bits;
        exp_bits = 10'h2AA;
        send_one(0, 8'h55, line, blen, lt, lb);
        n_vec++;
        if (lt !== 1'b1 || lb !== 1'b0) begin
            n_err++; $display("FAIL 8n1_pop_cycle: got tx %b busy %b expected 1 0", lt, lb);
        end
        n_vec++;
        if (blen != 100) begin
            n_err++; $display("FAIL 8n1_busy_len: got %0d expected 100", blen);
        end
        for (int c = 0; c < 120; c++) begin
            e = (c < 100) ? exp_bits[c / 10] : 1'b1;
            n_vec++;
            if (line[c] !== e) begin
                n_err++; $display("FAIL 8n1_line[%0d]: got %b expected %b", c, line[c], e);
            end
        end
    endtask

    task automatic test_parity;
        logic [299:0] line; int blen; logic lt, lb, e;
        logic [10:0] exp_bits;
        for (int p = 0; p < 2; p++) begin
            exp_bits = (p == 0) ? 11'h60E : 11'h40E;
            send_one(p + 1, 8'h07, line, blen, lt, lb);
            n_vec++;
            if (blen != 110) begin
                n_err++; $display("FAIL parity%0d_busy_len: got %0d expected 110", p, blen);
            end
            for (int c = 0; c < 130; c++) begin
                e = (c < 110) ? exp_bits[c / 10] : 1'b1;
                n_vec++;
                if (line[c] !== e) begin
                    n_err++; $display("FAIL parity%0d_line[%0d]: got %b expected %b", p, c, line[c], e);
                end
            end
        end
    endtask

    task automatic test_msb_5b2s;
        logic [299:0] line; int blen; logic lt, lb, e;
        logic [7:0] exp_bits;
        exp_bits = 8'hC2;
        send_one(3, 8'h10, line, blen, lt, lb);
        n_vec++;
        if (blen != 80) begin
            n_err++; $display("FAIL msb_busy_len: got %0d expected 80", blen);
        end
        for (int c = 0; c < 100; c++) begin
            e = (c < 80) ? exp_bits[c / 10] : 1'b1;
            n_vec++;
            if (line[c] !== e) begin
                n_err++; $display("FAIL msb_line[%0d]: got %b expected %b", c, line[c], e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [840:0] line; logic [7:0] w; logic e, prev_busy; bit acc;
        int idx, maxlvl, blen, nfall, first_busy, t_bit;
        sel = 0; idx = 0; maxlvl = 0; blen = 0; nfall = 0; first_busy = -1; prev_busy = 1'b0;
        line = '1;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'd1;
        acc = valid_a && rdy_a;
        for (int t = 1; t <= 840; t++) begin
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx >= 8) valid_a = 1'b0;
                else data_a = 8'(idx + 1);
            end
            line[t] = tx_a;
            if (int'(lvl_a) > maxlvl) maxlvl = int'(lvl_a);
            if (busy_a) begin
                blen++;
                if (first_busy < 0) first_busy = t;
            end
            if (prev_busy && !busy_a) nfall++;
            prev_busy = busy_a;
            if (t == 5) begin
                n_vec++;
                if (lvl_a !== 3'(C_FULL_LVL) || rdy_a !== 1'b0) begin
                    n_err++; $display("FAIL fill_full: got level %0d ready %b expected %0d 0", lvl_a, rdy_a, C_FULL_LVL);
                end
            end
            if (t == 101) begin
                n_vec++;
                if (rdy_a !== 1'b0) begin
                    n_err++; $display("FAIL fill_ready_before_pop: got %b expected 0", rdy_a);
                end
            end
            if (t == 102 || t == 202 || t == 302) begin
                n_vec++;
                if (rdy_a !== 1'b1) begin
                    n_err++; $display("FAIL fill_ready_after_pop@%0d: got %b expected 1", t, rdy_a);
                end
            end
            if (t == 102) begin
                n_vec++;
                if (lvl_a !== 3'(C_AFTER_POP)) begin
                    n_err++; $display("FAIL fill_level_after_pop: got %0d expected %0d", lvl_a, C_AFTER_POP);
                end
            end
            acc = valid_a && rdy_a;
        end
        n_vec++;
        if (idx != 8) begin
            n_err++; $display("FAIL fill_accepted: got %0d expected 8", idx);
        end
        n_vec++;
        if (maxlvl != C_FULL_LVL) begin
            n_err++; $display("FAIL fill_max_level: got %0d expected %0d", maxlvl, C_FULL_LVL);
        end
        n_vec++;
        if (blen != 800 || first_busy != 3 || nfall != 1) begin
            n_err++; $display("FAIL fill_gapless: got busy %0d from %0d falls %0d expected 800 3 1", blen, first_busy, nfall);
        end
        for (int k = 0; k < 8; k++) begin
            w = 8'(k + 1);
            for (int b = 0; b < 10; b++) begin
                t_bit = 3 + 100 * k + 10 * b + 5;
                e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[b - 1];
                n_vec++;
                if (line[t_bit] !== e) begin
                    n_err++; $display("FAIL fill_word%0d_bit%0d: got %b expected %b", k + 1, b, line[t_bit], e);
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        bit acc; int idx, stray;
        sel = 0; idx = 0; stray = 0;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'hA1;
        acc = valid_a && rdy_a;
        for (int t = 1; t <= 48; t++) begin
            @(negedge clk);
            if (acc) begin
                idx++;
                data_a = 8'(8'hA1 + idx);
            end
            if (t == 4) valid_a = 1'b0;
            acc = valid_a && rdy_a;
        end
        n_vec++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1 || lvl_a !== 3'(C_RST_LVL)) begin
            n_err++; $display("FAIL midframe_pre: got tx %b busy %b level %0d expected 0 1 %0d", tx_a, busy_a, lvl_a, C_RST_LVL);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || lvl_a !== 3'd0) begin
            n_err++; $display("FAIL midframe_reset: got tx %b busy %b level %0d expected 1 0 0", tx_a, busy_a, lvl_a);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rdy_a !== 1'b1) begin
            n_err++; $display("FAIL midframe_ready: got %b expected 1", rdy_a);
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) stray++;
        end
        n_vec++;
        if (stray != 0) begin
            n_err++; $display("FAIL midframe_stray: got %0d active cycles expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_msb_5b2s();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
